// File: rtl/aes_pkg.sv
// Shared AES constants, scheduler state encoding and a byte-lane slicing helper.
package aes_pkg;
    localparam int AES_NBYTES = 16;
    localparam int AES_BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

    function automatic logic [AES_BYTE_W-1:0] get_byte(
        input logic [AES_NBYTES*AES_BYTE_W-1:0] s,
        input logic [3:0]                       idx
    );
        return s[idx*AES_BYTE_W +: AES_BYTE_W];
    endfunction
endpackage

// File: rtl/sbox_capture_pipe.sv
// DEPTH-deep {valid, byte index} delay line that tracks each ROM read until its data returns.
module sbox_capture_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clr,
    input  logic             vld_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic             vld_out,
    output logic [IDX_W-1:0] idx_out
);
    logic [DEPTH-1:0] vld_p;
    logic [IDX_W-1:0] idx_p [DEPTH];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p <= '0;
        end else if (clr) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= vld_in;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Indices are only meaningful alongside a set valid bit, so they need no reset.
    always_ff @(posedge sys_clk) begin
        idx_p[0] <= idx_in;
        for (int i = 1; i < DEPTH; i++) begin
            idx_p[i] <= idx_p[i-1];
        end
    end

    assign vld_out = vld_p[DEPTH-1];
    assign idx_out = idx_p[DEPTH-1];
endmodule

// File: rtl/inv_sbox_scheduler.sv
// Streams the 16 bytes of an AES state through one shared inverse S-box ROM, one per clock,
// and reassembles the substituted bytes into a 128-bit result.
module inv_sbox_scheduler
    import aes_pkg::*;
#(
    parameter int ROM_LATENCY = 1,
    parameter int NBYTES      = AES_NBYTES
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBYTES*AES_BYTE_W-1:0] in_state,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NBYTES*AES_BYTE_W-1:0] out_state,
    output logic [AES_BYTE_W-1:0]        rom_adr,
    input  logic [AES_BYTE_W-1:0]        rom_dat,
    output logic                         busy
);
    localparam logic [4:0] LAST_CNT = 5'(NBYTES - 1);
    localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

    sched_state_t                  state;
    logic [4:0]                    issue_cnt;
    logic [NBYTES*AES_BYTE_W-1:0]  in_buf;
    logic                          cap_vld;
    logic [3:0]                    cap_idx;

    assign in_ready = (state == IDLE) & ~flush;
    assign busy     = (state != IDLE);
    assign rom_adr  = (state == ISSUE) ? get_byte(in_buf, issue_cnt[3:0]) : '0;

    // Issue -> capture boundary: the index rides alongside the ROM read latency.
    sbox_capture_pipe #(
        .DEPTH (ROM_LATENCY),
        .IDX_W (4)
    ) u_capture_pipe (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (flush),
        .vld_in    (state == ISSUE),
        .idx_in    (issue_cnt[3:0]),
        .vld_out   (cap_vld),
        .idx_out   (cap_idx)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            in_buf    <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            // Partially written out_state is deliberately left as is.
            state     <= IDLE;
            issue_cnt <= '0;
            out_valid <= 1'b0;
        end else begin
            if (cap_vld) begin
                out_state[cap_idx*AES_BYTE_W +: AES_BYTE_W] <= rom_dat;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_buf    <= in_state;
                        issue_cnt <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    issue_cnt <= issue_cnt + 5'd1;
                    if (issue_cnt == LAST_CNT) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cap_vld && (cap_idx == LAST_IDX)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sbox_scheduler.sv
// Bench: two schedulers (ROM latency 1 and 2) share stimulus; each has its own ROM model
// and a transaction-level reference that is checked on every cycle.
module tb_inv_sbox_scheduler;
    localparam int LAT [2] = '{1, 2};

    logic         sys_clk;
    logic         sys_rst_n;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_ready;

    logic [1:0]   in_ready_w;
    logic [1:0]   out_valid_w;
    logic [1:0]   busy_w;
    logic [127:0] out_state_w [2];
    logic [7:0]   rom_adr_w [2];
    logic [7:0]   rom_dat_w [2];

    logic [7:0]   isb [256];
    logic [7:0]   rd0, rd1a, rd1b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    inv_sbox_scheduler #(.ROM_LATENCY(1)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_state(in_state),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_state(out_state_w[0]),
        .rom_adr(rom_adr_w[0]), .rom_dat(rom_dat_w[0]), .busy(busy_w[0])
    );

    inv_sbox_scheduler #(.ROM_LATENCY(2)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_state(in_state),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_state(out_state_w[1]),
        .rom_adr(rom_adr_w[1]), .rom_dat(rom_dat_w[1]), .busy(busy_w[1])
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Synchronous-read ROMs, one per latency; never reset.
    always @(posedge sys_clk) begin
        rd0  <= isb[rom_adr_w[0]];
        rd1a <= isb[rom_adr_w[1]];
        rd1b <= rd1a;
    end
    assign rom_dat_w[0] = rd0;
    assign rom_dat_w[1] = rd1b;

    // GF(2^8) arithmetic used to derive the inverse S-box from first principles.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] inv_all(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = isb[s[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input int lane, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lane%0d got=%h want=%h t=%0t", name, lane, act, exp, $time);
        end
    endtask

    task automatic tfail(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // Reference: per lane, counts edges since the accepting edge.
    logic         m_busy [2];
    logic         m_done [2];
    logic         m_zero [2];
    int           m_cnt  [2];
    logic [127:0] m_buf  [2];
    logic [127:0] m_exp  [2];

    always @(posedge sys_clk or negedge sys_rst_n) begin
        for (int l = 0; l < 2; l++) begin
            if (!sys_rst_n) begin
                m_busy[l] <= 1'b0;
                m_done[l] <= 1'b0;
                m_zero[l] <= 1'b1;
                m_cnt[l]  <= 0;
            end else if (flush) begin
                m_busy[l] <= 1'b0;
                m_done[l] <= 1'b0;
            end else if (!m_busy[l]) begin
                if (in_valid) begin
                    m_busy[l] <= 1'b1;
                    m_cnt[l]  <= 0;
                    m_buf[l]  <= in_state;
                    m_exp[l]  <= inv_all(in_state);
                    m_zero[l] <= 1'b0;
                end
            end else if (!m_done[l]) begin
                m_cnt[l] <= m_cnt[l] + 1;
                if (m_cnt[l] + 1 == 16 + LAT[l]) m_done[l] <= 1'b1;
            end else if (out_ready) begin
                m_busy[l] <= 1'b0;
                m_done[l] <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] exp_adr(input int l);
        if (m_busy[l] && !m_done[l] && m_cnt[l] < 16) return m_buf[l][8*m_cnt[l] +: 8];
        return 8'h00;
    endfunction

    always @(negedge sys_clk) begin
        if (chk_en) begin
            for (int l = 0; l < 2; l++) begin
                if (sys_rst_n) chk("in_ready", l, 128'(in_ready_w[l]), 128'(!m_busy[l] && !flush));
                chk("out_valid", l, 128'(out_valid_w[l]), 128'(m_done[l]));
                chk("busy", l, 128'(busy_w[l]), 128'(m_busy[l]));
                chk("rom_adr", l, 128'(rom_adr_w[l]), 128'(exp_adr(l)));
                if (m_done[l]) chk("out_state", l, out_state_w[l], m_exp[l]);
                else if (m_zero[l]) chk("out_state_zero", l, out_state_w[l], 128'h0);
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] s);
        int n = 0;
        while (in_ready_w != 2'b11 && n < 80) begin
            step();
            n++;
        end
        if (in_ready_w != 2'b11) tfail("accept_wait");
        in_valid = 1'b1;
        in_state = s;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [127:0] s, input logic [127:0] expv, input bit hold);
        int rise [2];
        rise[0] = -1;
        rise[1] = -1;
        accept(s);
        for (int c = 1; c <= 40 && (rise[0] < 0 || rise[1] < 0); c++) begin
            step();
            for (int l = 0; l < 2; l++) if (rise[l] < 0 && out_valid_w[l]) rise[l] = c;
        end
        for (int l = 0; l < 2; l++) begin
            if (rise[l] < 0) tfail({name, "_rise"});
            else chk({name, "_rise_edge"}, l, 128'(rise[l]), 128'(16 + LAT[l]));
            chk({name, "_data"}, l, out_state_w[l], expv);
        end
        if (hold) begin
            repeat (10) step();
            for (int l = 0; l < 2; l++) begin
                chk({name, "_hold_ready"}, l, 128'(in_ready_w[l]), 128'h0);
                chk({name, "_hold_valid"}, l, 128'(out_valid_w[l]), 128'h1);
                chk({name, "_hold_data"}, l, out_state_w[l], expv);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int l = 0; l < 2; l++) begin
            chk({name, "_idle_ready"}, l, 128'(in_ready_w[l]), 128'h1);
            chk({name, "_idle_valid"}, l, 128'(out_valid_w[l]), 128'h0);
        end
    endtask

    initial begin
        logic [127:0] rnd;
        sys_rst_n = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;

        for (int x = 0; x < 256; x++) isb[fwd_sbox(8'(x))] = 8'(x);
        chk("isb_00", 0, 128'(isb[8'h00]), 128'h52);
        chk("isb_01", 0, 128'(isb[8'h01]), 128'h09);
        chk("isb_63", 0, 128'(isb[8'h63]), 128'h00);
        chk("isb_ff", 0, 128'(isb[8'hff]), 128'h7d);

        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        chk_en    = 1'b1;
        chk("first_ready", 0, 128'(in_ready_w), 128'h3);

        run_check("zeros", 128'h0, {16{8'h52}}, 1'b0);

        // Mid-run asynchronous reset while both lanes are issuing.
        accept(128'h0f0e0d0c0b0a09080706050403020100);
        repeat (5) step();
        #2;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        for (int l = 0; l < 2; l++) begin
            chk("rst_valid", l, 128'(out_valid_w[l]), 128'h0);
            chk("rst_busy", l, 128'(busy_w[l]), 128'h0);
            chk("rst_adr", l, 128'(rom_adr_w[l]), 128'h0);
            chk("rst_state", l, out_state_w[l], 128'h0);
        end
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b1;
        step();
        chk("rel_ready", 0, 128'(in_ready_w), 128'h3);

        run_check("ramp", 128'h0f0e0d0c0b0a09080706050403020100,
                  128'hfbd7f3819ea340bf38a53630d56a0952, 1'b1);

        // Flush during cycle 8 of ISSUE, then an immediate accept.
        accept({$urandom, $urandom, $urandom, $urandom});
        repeat (8) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 0, 128'(busy_w), 128'h0);
        chk("flush_valid", 0, 128'(out_valid_w), 128'h0);
        run_check("post_flush", {16{8'h63}}, 128'h0, 1'b0);

        // Flush together with in_valid in IDLE must not accept.
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_noacc", 0, 128'(busy_w), 128'h0);

        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_check("rand_dir", rnd, inv_all(rnd), 1'b0);

        // Random traffic; lanes drift apart and the reference tracks each.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
